game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Parametrised game-flow controller for the Pac-Man FPGA design. It tracks the player's lives and sequences the game through init, play, pause, post-death resume, game-over and level-won phases. It drives the sprite/map reset and enable strobes consumed by `pacman_loc_ctrl`, `ghosts_ai` and `map_RAM_writer`. It sits between the switch/keyboard inputs and the sprite controllers, and supports any number of ghosts.

## Interface
Parameters:
- `NUM_GHOSTS`, 2: number of ghost channels compared against Pac-Man (≥1).
- `LIVES`, 3: lives loaded at reset/soft reset (1..7).
- `RESUME_CYCLES`, 250000000: RESUME dwell in clock cycles (5 s at 50 MHz), ≥2.
- `X_W`, 6: grid x width.
- `Y_W`, 5: grid y width.
- `PILL_W`, 10: pill-remaining counter width.

Ports:
- `CLOCK_50`  in  1  system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous; when 1, forces INIT and reloads lives (SW[0]).
- `start`  in  1  level; leaves INIT (SW[9]).
- `pause`  in  1  level; holds GAME in PAUSE while high.
- `pac_x` / `pac_y`  in  X_W / Y_W  Pac-Man next grid position.
- `ghost_x`  in  NUM_GHOSTS*X_W  ghost next x; ghost i is at bits [i*X_W +: X_W].
- `ghost_y`  in  NUM_GHOSTS*Y_W  ghost next y; same packing.
- `pills_left`  in  PILL_W  pills remaining on the map.
- `lives`  out  $clog2(LIVES+1)  remaining lives.
- `sprite_reset`, `map_wr_reset`  out  1  active-high resets to the sprite controllers and the map writer.
- `ghost_enable`, `pac_enable`  out  1  motion enables.
- `life_lost`  out  1  one-cycle pulse per death.
- `game_over`, `game_won`  out  1  terminal status flags.
- `state`  out  3  encoded state: INIT=0, GAME=1, PAUSE=2, RESUME=3, OVER=4, WON=5.

## Operation
- `hit` is the combinational OR over i of (`ghost_x[i]`==`pac_x` & `ghost_y[i]`==`pac_y`).
- `clear` = (`pills_left`==0).
- State transitions (priority top to bottom):
  - `soft_reset`: any state → INIT; lives ← LIVES.
  - INIT → GAME when `start`=1.
  - GAME → WON when `clear` (beats `hit` in the same cycle).
  - GAME → OVER when `hit` & lives==1. Lives ← 0, pulse `life_lost`.
  - GAME → RESUME when `hit` & lives>1. Lives ← lives−1, pulse `life_lost`. Load resume counter with RESUME_CYCLES−1.
  - GAME → PAUSE when `pause`; PAUSE → GAME when `pause`=0. `hit` and `clear` are ignored in PAUSE.
  - RESUME: the counter decrements each cycle; → GAME the cycle after it reads 0. `hit` is ignored.
  - OVER and WON are absorbing; only `soft_reset` or `reset_n` leave them.
- Output decode from the state register:
  - INIT: `sprite_reset`=1, `map_wr_reset`=1, both enables=0.
  - GAME: both resets=0, both enables=1.
  - PAUSE: both resets=0, both enables=0.
  - RESUME: `sprite_reset`=1, `map_wr_reset`=0 (eaten pills persist), enables=0.
  - OVER: resets=0, enables=0, `game_over`=1.
  - WON: resets=0, enables=0, `game_won`=1.
- Lives never underflow and never decrement outside GAME. Exactly one decrement occurs per collision, because GAME is left on the same edge.

## Timing
- `reset_n` low: immediately state=INIT, lives=LIVES, `sprite_reset`=1, `map_wr_reset`=1, `ghost_enable`=`pac_enable`=0, `life_lost`=`game_over`=`game_won`=0, resume counter=0.
- Reset is released synchronously to CLOCK_50; the first transition can occur on the first rising edge with `reset_n` high.
- All outputs are registered or decoded from registers, with no combinational input→output path. Outputs change one cycle after the qualifying input is sampled.
- `life_lost` is high for exactly the cycle in which the new state is RESUME or OVER.
- RESUME lasts exactly RESUME_CYCLES cycles; `sprite_reset` is high for all of them.
- `soft_reset` mid-RESUME abandons the count; the counter value is don't-care until the next load.
- `reset_n` asserted mid-operation aborts any state immediately.

## Test plan
- Reset/start: hold `reset_n`=0 → lives=3, state=0, `sprite_reset`=1. Release, set `start`=1 → state=1 one cycle later, enables=1.
- Death with resume (RESUME_CYCLES=4, NUM_GHOSTS=3): in GAME, ghost 2 at (5,7) with pac at (5,7) → `life_lost` pulses once, lives=2, state=3 for exactly 4 cycles, then state=1.
- Final death: lives=1 and `hit` → lives=0, state=4, `game_over`=1. Further hits, `start` and `pause` cause no change.
- Simultaneous events: `pills_left`=0 and `hit` in the same cycle with lives=2 → state=5, `game_won`=1, lives stays 2, no `life_lost`.
- Pause: `pause`=1 in GAME → state=2, enables=0. A `hit` while paused leaves lives unchanged. `pause`=0 → GAME.
- Soft reset from OVER and mid-RESUME → state=0, lives=3, `game_over`=0, `sprite_reset`=1.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: tracks lives and sequences INIT/GAME/PAUSE/RESUME/OVER/WON,
// driving the sprite/map reset and motion-enable strobes from the state register.
module game_flow_ctrl #(
    parameter int NUM_GHOSTS    = 2,
    parameter int LIVES         = 3,
    parameter int RESUME_CYCLES = 250000000,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int PILL_W        = 10
) (
    input  logic                            CLOCK_50,
    input  logic                            reset_n,
    input  logic                            soft_reset,
    input  logic                            start,
    input  logic                            pause,
    input  logic [X_W-1:0]                  pac_x,
    input  logic [Y_W-1:0]                  pac_y,
    input  logic [NUM_GHOSTS*X_W-1:0]       ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]       ghost_y,
    input  logic [PILL_W-1:0]               pills_left,
    output logic [$clog2(LIVES+1)-1:0]      lives,
    output logic                            sprite_reset,
    output logic                            map_wr_reset,
    output logic                            ghost_enable,
    output logic                            pac_enable,
    output logic                            life_lost,
    output logic                            game_over,
    output logic                            game_won,
    output logic [2:0]                      state
);

    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int CNT_W = (RESUME_CYCLES > 2) ? $clog2(RESUME_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_GAME   = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_RESUME = 3'd3,
        ST_OVER   = 3'd4,
        ST_WON    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [LIV_W-1:0]   lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               life_lost_q, life_lost_d;
    logic               hit_s;
    logic               clear_s;

    // Collision: any ghost sharing Pac-Man's next grid cell.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            hit_s = hit_s | ((ghost_x[i*X_W +: X_W] == pac_x) &&
                             (ghost_y[i*Y_W +: Y_W] == pac_y));
        end
    end

    assign clear_s = (pills_left == {PILL_W{1'b0}});

    // State, lives, resume counter and death pulse registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            lives_q     <= LIV_W'(LIVES);
            cnt_q       <= {CNT_W{1'b0}};
            life_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            life_lost_q <= life_lost_d;
        end
    end

    // Next-state logic; GAME is left on the same edge as a collision, so one decrement per death.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        life_lost_d = 1'b0;
        if (soft_reset) begin
            state_d = ST_INIT;
            lives_d = LIV_W'(LIVES);
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (start) begin
                        state_d = ST_GAME;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_GAME: begin
                    if (clear_s) begin
                        state_d = ST_WON;
                    end else if (hit_s) begin
                        life_lost_d = 1'b1;
                        if (lives_q <= LIV_W'(1)) begin
                            state_d = ST_OVER;
                            lives_d = {LIV_W{1'b0}};
                        end else begin
                            state_d = ST_RESUME;
                            lives_d = lives_q - LIV_W'(1);
                            cnt_d   = CNT_W'(RESUME_CYCLES - 1);
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_GAME;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_GAME;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_RESUME: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_GAME;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_OVER:  state_d = ST_OVER;
                ST_WON:   state_d = ST_WON;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    // Output decode from the state register; RESUME keeps the map so eaten pills persist.
    always_comb begin
        sprite_reset = 1'b0;
        map_wr_reset = 1'b0;
        ghost_enable = 1'b0;
        pac_enable   = 1'b0;
        game_over    = 1'b0;
        game_won     = 1'b0;
        case (state_q)
            ST_INIT: begin
                sprite_reset = 1'b1;
                map_wr_reset = 1'b1;
            end
            ST_GAME: begin
                ghost_enable = 1'b1;
                pac_enable   = 1'b1;
            end
            ST_RESUME: sprite_reset = 1'b1;
            ST_OVER:   game_over    = 1'b1;
            ST_WON:    game_won     = 1'b1;
            default:   sprite_reset = 1'b0;
        endcase
    end

    assign lives     = lives_q;
    assign life_lost = life_lost_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then randomized play, checked against
// a phase/lives model that counts time spent in RESUME.
module tb_game_flow_ctrl;

    localparam int NG    = 3;
    localparam int LIVES = 3;
    localparam int RC    = 4;
    localparam int XW    = 6;
    localparam int YW    = 5;
    localparam int PW    = 10;

    localparam int S_INIT   = 0;
    localparam int S_GAME   = 1;
    localparam int S_PAUSE  = 2;
    localparam int S_RESUME = 3;
    localparam int S_OVER   = 4;
    localparam int S_WON    = 5;

    logic                CLOCK_50 = 1'b0;
    logic                reset_n;
    logic                soft_reset;
    logic                start;
    logic                pause;
    logic [XW-1:0]       pac_x;
    logic [YW-1:0]       pac_y;
    logic [NG*XW-1:0]    ghost_x;
    logic [NG*YW-1:0]    ghost_y;
    logic [PW-1:0]       pills_left;
    logic [1:0]          lives;
    logic                sprite_reset, map_wr_reset, ghost_enable, pac_enable;
    logic                life_lost, game_over, game_won;
    logic [2:0]          state;

    int n_checks = 0;
    int n_errors = 0;

    int px, py;
    int gx[NG];
    int gy[NG];

    int m_state, m_lives, m_elapsed;
    bit m_life_lost;

    game_flow_ctrl #(
        .NUM_GHOSTS(NG), .LIVES(LIVES), .RESUME_CYCLES(RC),
        .X_W(XW), .Y_W(YW), .PILL_W(PW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .soft_reset(soft_reset),
        .start(start), .pause(pause), .pac_x(pac_x), .pac_y(pac_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .pills_left(pills_left),
        .lives(lives), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .ghost_enable(ghost_enable), .pac_enable(pac_enable), .life_lost(life_lost),
        .game_over(game_over), .game_won(game_won), .state(state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".state"},        int'(state),        m_state);
        check_eq({ph, ".lives"},        int'(lives),        m_lives);
        check_eq({ph, ".sprite_reset"}, int'(sprite_reset), int'(m_state == S_INIT || m_state == S_RESUME));
        check_eq({ph, ".map_wr_reset"}, int'(map_wr_reset), int'(m_state == S_INIT));
        check_eq({ph, ".ghost_enable"}, int'(ghost_enable), int'(m_state == S_GAME));
        check_eq({ph, ".pac_enable"},   int'(pac_enable),   int'(m_state == S_GAME));
        check_eq({ph, ".life_lost"},    int'(life_lost),    int'(m_life_lost));
        check_eq({ph, ".game_over"},    int'(game_over),    int'(m_state == S_OVER));
        check_eq({ph, ".game_won"},     int'(game_won),     int'(m_state == S_WON));
    endtask

    function automatic bit model_hit();
        bit h = 1'b0;
        for (int i = 0; i < NG; i++)
            if (gx[i] == px && gy[i] == py) h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        m_state     = S_INIT;
        m_lives     = LIVES;
        m_life_lost = 1'b0;
        m_elapsed   = 0;
    endtask

    task automatic model_update();
        bit hit;
        bit clear;
        hit = model_hit();
        clear = (pills_left == '0);
        m_life_lost = 1'b0;
        if (soft_reset) begin
            m_state = S_INIT;
            m_lives = LIVES;
        end else begin
            case (m_state)
                S_INIT: if (start) m_state = S_GAME;
                S_GAME: begin
                    if (clear) m_state = S_WON;
                    else if (hit) begin
                        m_lives--;
                        m_life_lost = 1'b1;
                        if (m_lives == 0) m_state = S_OVER;
                        else begin
                            m_state   = S_RESUME;
                            m_elapsed = 1;
                        end
                    end else if (pause) m_state = S_PAUSE;
                end
                S_PAUSE:  if (!pause) m_state = S_GAME;
                S_RESUME: begin
                    if (m_elapsed == RC) m_state = S_GAME;
                    else m_elapsed++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic apply_inputs();
        pac_x = XW'(px);
        pac_y = YW'(py);
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*XW +: XW] = XW'(gx[i]);
            ghost_y[i*YW +: YW] = YW'(gy[i]);
        end
    endtask

    task automatic step(input string ph);
        apply_inputs();
        @(posedge CLOCK_50);
        model_update();
        #1;
        check_outputs(ph);
    endtask

    task automatic ghosts_away();
        px = 1;
        py = 1;
        for (int i = 0; i < NG; i++) begin
            gx[i] = 20 + i;
            gy[i] = 20 + i;
        end
    endtask

    task automatic ghost2_hit();
        px = 5;
        py = 7;
        gx[2] = 5;
        gy[2] = 7;
    endtask

    task automatic async_reset(input string ph);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs({ph, ".now"});
        @(posedge CLOCK_50);
        #1;
        check_outputs({ph, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        soft_reset = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        pills_left = PW'(100);
        ghosts_away();
        apply_inputs();
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        start = 1'b1; step("start");
        start = 1'b0; step("game");

        // Death with resume, RESUME dwell, then second death and final death.
        ghost2_hit(); step("hit1");
        ghosts_away();
        repeat (RC) step("resume1");
        ghost2_hit(); step("hit2");
        ghosts_away();
        repeat (RC) step("resume2");
        ghost2_hit(); step("hit3");
        start = 1'b1; pause = 1'b1;
        repeat (3) step("over_hold");
        start = 1'b0; pause = 1'b0;

        soft_reset = 1'b1; step("srst_over");
        soft_reset = 1'b0; ghosts_away();
        start = 1'b1; step("restart");
        start = 1'b0;

        // Pause ignores collisions.
        pause = 1'b1; step("pause");
        ghost2_hit(); step("pause_hit");
        pills_left = '0; step("pause_clear");
        pills_left = PW'(50); ghosts_away();
        pause = 1'b0; step("unpause");

        // Soft reset in the middle of RESUME.
        ghost2_hit(); step("hit_r");
        ghosts_away(); step("resume_mid");
        soft_reset = 1'b1; step("srst_resume");
        soft_reset = 1'b0; start = 1'b1; step("restart2");
        start = 1'b0;

        // Clear beats hit.
        ghost2_hit(); step("hit_w");
        ghosts_away();
        repeat (RC) step("resume_w");
        ghost2_hit(); pills_left = '0; step("clear_hit");
        step("won_hold");
        pills_left = PW'(50); ghosts_away();
        soft_reset = 1'b1; step("srst_won");
        soft_reset = 1'b0; start = 1'b1; step("restart3");
        start = 1'b0;

        // Async reset aborting RESUME.
        ghost2_hit(); step("hit_a");
        ghosts_away();
        async_reset("arst_resume");

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            px = int'($urandom_range(0, 7));
            py = int'($urandom_range(0, 7));
            for (int i = 0; i < NG; i++) begin
                gx[i] = int'($urandom_range(0, 7));
                gy[i] = int'($urandom_range(0, 7));
            end
            pills_left = ($urandom_range(0, 59) == 0) ? '0 : PW'($urandom_range(1, 1023));
            start      = ($urandom_range(0, 3) == 0);
            soft_reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 399) == 0) begin
                apply_inputs();
                async_reset("arst_rand");
            end else begin
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
